store_buffer: RTL and testbench

- Word-granular store FIFO between the EX/MEM pipeline register and the data memory.
- Accepts committed stores from the pipeline, one per cycle.
- Drains them in order to the DM write port (address, data, write enable, PC for the trace display), one per cycle.
- Serves loads by forwarding the youngest buffered store to the same word, so loads never see stale DM contents.

---
 rtl/store_buffer.sv | 138 +++++++++++++
 tb/tb_store_buffer.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/store_buffer.sv
// store_buffer: word-granular in-order store FIFO between EX/MEM and data memory.
// Drains one store per cycle to the DM write port and forwards the youngest
// buffered store to a matching load. Optional store merging: STB_MERGE_EN.
module store_buffer #(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              st_valid,
  input  logic [31:0]       st_addr,
  input  logic [31:0]       st_data,
  input  logic [31:0]       st_pc,
  output logic              st_ready,
  input  logic              drain_hold,
  output logic              mem_we,
  output logic [31:0]       mem_addr,
  output logic [31:0]       mem_din,
  output logic [31:0]       mem_pc,
  input  logic [31:0]       ld_addr,
  output logic              ld_hit,
  output logic [31:0]       ld_data,
  output logic [PTR_W:0]    count,
  output logic              empty
);

  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

  logic              valid_q [DEPTH];
  logic [31:0]       addr_q  [DEPTH];
  logic [31:0]       data_q  [DEPTH];
  logic [31:0]       pc_q    [DEPTH];

  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W:0]    count_q, count_d;
  logic [PTR_W-1:0]  fwd_idx;

  logic              push, pop, merge, alloc;

  // Only the word index of a load address takes part in the match.
  logic              ld_addr_unused;
  assign ld_addr_unused = ^{ld_addr[31:12], ld_addr[1:0]};

  assign empty    = (count_q == '0);
  assign st_ready = (count_q != FULL_CNT);
  assign count    = count_q;
  assign mem_we   = !empty && !drain_hold;
  assign pop      = mem_we;
  assign push     = st_valid && st_ready;

`ifdef STB_MERGE_EN
  logic [PTR_W-1:0]  young_idx;
  assign young_idx = wr_ptr_q - PTR_W'(1);
  // Youngest entry equals the head only when it is the sole entry; a merge
  // into an entry that is draining this cycle would be lost, so allocate instead.
  assign merge = push && !empty && (st_addr[11:2] == addr_q[young_idx][11:2])
               && !(pop && (young_idx == rd_ptr_q));
`else
  assign merge = 1'b0;
`endif

  assign alloc = push && !merge;

  // Head entry drives the DM write port; zero when nothing is buffered.
  always_comb begin
    mem_addr = '0;
    mem_din  = '0;
    mem_pc   = '0;
    if (!empty) begin
      mem_addr = addr_q[rd_ptr_q];
      mem_din  = data_q[rd_ptr_q];
      mem_pc   = pc_q[rd_ptr_q];
    end
  end

  // Load forwarding: walk entries oldest to youngest so the youngest match wins.
  always_comb begin
    ld_hit  = 1'b0;
    ld_data = '0;
    fwd_idx = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      fwd_idx = rd_ptr_q + PTR_W'(i);
      if (valid_q[fwd_idx] && (addr_q[fwd_idx][11:2] == ld_addr[11:2])) begin
        ld_hit  = 1'b1;
        ld_data = data_q[fwd_idx];
      end
    end
  end

  // Next-state pointers and occupancy.
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (pop)   rd_ptr_d = rd_ptr_q + PTR_W'(1);
    if (alloc) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    case ({alloc, pop})
      2'b10:   count_d = count_q + (PTR_W+1)'(1);
      2'b01:   count_d = count_q - (PTR_W+1)'(1);
      default: count_d = count_q;
    endcase
  end

  // Control state with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) valid_q[i] <= 1'b0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      if (pop)   valid_q[rd_ptr_q] <= 1'b0;
      if (alloc) valid_q[wr_ptr_q] <= 1'b1;
    end
  end

  // Entry payload; contents are qualified by the valid bits, so no reset needed.
  always_ff @(posedge clk) begin
    if (reset) begin
      if (alloc) begin
        addr_q[wr_ptr_q] <= st_addr;
        data_q[wr_ptr_q] <= st_data;
        pc_q[wr_ptr_q]   <= st_pc;
      end
`ifdef STB_MERGE_EN
      if (merge) begin
        data_q[young_idx] <= st_data;
        pc_q[young_idx]   <= st_pc;
      end
`endif
    end
  end

endmodule

// File: tb/tb_store_buffer.sv
// tb_store_buffer: directed scenarios plus randomized traffic for store_buffer,
// checked every cycle against a queue-based reference model.
module tb_store_buffer;

  localparam int DEPTH = 4;
  localparam int PTR_W = 2;

  logic              clk = 1'b0;
  logic              reset;
  logic              st_valid;
  logic [31:0]       st_addr, st_data, st_pc;
  logic              st_ready;
  logic              drain_hold;
  logic              mem_we;
  logic [31:0]       mem_addr, mem_din, mem_pc;
  logic [31:0]       ld_addr;
  logic              ld_hit;
  logic [31:0]       ld_data;
  logic [PTR_W:0]    count;
  logic              empty;

  store_buffer #(.DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
    .clk(clk), .reset(reset),
    .st_valid(st_valid), .st_addr(st_addr), .st_data(st_data), .st_pc(st_pc),
    .st_ready(st_ready), .drain_hold(drain_hold),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_din(mem_din), .mem_pc(mem_pc),
    .ld_addr(ld_addr), .ld_hit(ld_hit), .ld_data(ld_data),
    .count(count), .empty(empty)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [31:0] pc;
  } ent_t;

  ent_t model[$];
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  function automatic bit same_word(input logic [31:0] a, input logic [31:0] b);
    return a[11:2] == b[11:2];
  endfunction

  task automatic drive(input logic v, input logic [31:0] a, input logic [31:0] d,
                       input logic h, input logic [31:0] la);
    st_valid   = v;
    st_addr    = a;
    st_data    = d;
    st_pc      = d ^ 32'h0F0F_0000;
    drain_hold = h;
    ld_addr    = la;
  endtask

  // Compare every output against the reference model for the current inputs.
  task automatic settle();
    int          sz;
    logic        hit;
    logic [31:0] fd;
    ent_t        hd;
    #1;
    sz  = model.size();
    hit = 1'b0;
    fd  = '0;
    hd  = '{32'd0, 32'd0, 32'd0};
    if (sz > 0) hd = model[0];
    for (int i = sz - 1; i >= 0; i--) begin
      if (same_word(model[i].addr, ld_addr)) begin
        hit = 1'b1;
        fd  = model[i].data;
        break;
      end
    end
    check("count",    32'(count),    32'(sz));
    check("st_ready", 32'(st_ready), 32'(sz != DEPTH));
    check("empty",    32'(empty),    32'(sz == 0));
    check("mem_we",   32'(mem_we),   32'((sz != 0) && !drain_hold));
    check("mem_addr", mem_addr,      hd.addr);
    check("mem_din",  mem_din,       hd.data);
    check("mem_pc",   mem_pc,        hd.pc);
    check("ld_hit",   32'(ld_hit),   32'(hit));
    check("ld_data",  ld_data,       fd);
  endtask

  // Clock edge: update the model from the inputs the DUT samples, then return at negedge.
  task automatic advance();
    int sz;
    bit do_pop, do_push, merged;
    @(posedge clk);
    if (!reset) begin
      model.delete();
    end else begin
      sz      = model.size();
      do_pop  = (sz != 0) && !drain_hold;
      do_push = st_valid && (sz != DEPTH);
      merged  = 1'b0;
`ifdef STB_MERGE_EN
      if (do_push && sz != 0 && same_word(model[sz-1].addr, st_addr) && !(do_pop && sz == 1)) begin
        model[sz-1].data = st_data;
        model[sz-1].pc   = st_pc;
        merged = 1'b1;
      end
`endif
      if (do_pop) void'(model.pop_front());
      if (do_push && !merged) model.push_back('{st_addr, st_data, st_pc});
    end
    @(negedge clk);
  endtask

  task automatic step();
    settle();
    advance();
  endtask

  initial begin
    logic [31:0] r, la;
    logic        hold;

    // Reset state
    reset = 1'b0;
    drive(1'b0, '0, '0, 1'b0, '0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    model.delete();
    settle();
    check("rst_count", 32'(count),    32'd0);
    check("rst_ready", 32'(st_ready), 32'd1);
    check("rst_empty", 32'(empty),    32'd1);
    check("rst_we",    32'(mem_we),   32'd0);
    check("rst_addr",  mem_addr,      32'd0);
    advance();
    reset = 1'b1;

    // Single store drains the following cycle
    drive(1'b1, 32'h10, 32'hDEAD_BEEF, 1'b0, 32'h10);
    step();
    drive(1'b0, '0, '0, 1'b0, 32'h10);
    settle();
    check("s1_we",   32'(mem_we), 32'd1);
    check("s1_addr", mem_addr,    32'h10);
    check("s1_din",  mem_din,     32'hDEAD_BEEF);
    advance();
    settle();
    check("s1_empty", 32'(empty),  32'd1);
    check("s1_we0",   32'(mem_we), 32'd0);
    advance();

    // Fill while held, fifth store stalled, then drain in order
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 32'(i * 4), 32'h100 + 32'(i), 1'b1, 32'h0);
      settle();
      if (i == 4) begin
        check("full_ready", 32'(st_ready), 32'd0);
        check("full_count", 32'(count),    32'd4);
      end
      advance();
    end
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, '0, '0, 1'b0, 32'h0);
      settle();
      check("drain_we",   32'(mem_we), 32'd1);
      check("drain_addr", mem_addr,    32'(i * 4));
      advance();
    end
    settle();
    check("drain_empty", 32'(empty), 32'd1);
    advance();

    // Youngest-hit forwarding
    drive(1'b1, 32'h20, 32'h1111_1111, 1'b1, 32'h20);
    step();
    drive(1'b1, 32'h20, 32'h2222_2222, 1'b1, 32'h20);
    step();
    drive(1'b0, '0, '0, 1'b1, 32'h20);
    settle();
    check("fwd_hit",  32'(ld_hit), 32'd1);
    check("fwd_data", ld_data,     32'h2222_2222);
    ld_addr = 32'h24;
    settle();
    check("fwd_miss",  32'(ld_hit), 32'd0);
    check("fwd_zero",  ld_data,     32'd0);
    advance();
    drive(1'b0, '0, '0, 1'b0, 32'h0);
    repeat (3) step();

    // Steady push/pop with pointer wrap
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 32'h100 + 32'(i * 4), $urandom, 1'b1, 32'h100);
      step();
    end
    for (int i = 0; i < 12; i++) begin
      drive(st_ready, 32'h200 + 32'(i * 4), $urandom, 1'b0, 32'h200 + 32'(i * 4));
      settle();
      check("wrap_cnt_le4", 32'(count <= 3'(DEPTH)), 32'd1);
      advance();
    end
    drive(1'b0, '0, '0, 1'b0, 32'h0);
    repeat (5) step();

    // Reset mid-operation discards buffered and concurrent stores
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 32'h300 + 32'(i * 4), 32'hC0 + 32'(i), 1'b1, 32'h300);
      step();
    end
    reset = 1'b0;
    drive(1'b1, 32'h30C, 32'hC3, 1'b1, 32'h300);
    step();
    reset = 1'b1;
    drive(1'b0, '0, '0, 1'b0, 32'h300);
    for (int i = 0; i < 4; i++) begin
      ld_addr = 32'h300 + 32'(i * 4);
      settle();
      check("mrst_hit", 32'(ld_hit), 32'd0);
    end
    check("mrst_count", 32'(count),  32'd0);
    check("mrst_we",    32'(mem_we), 32'd0);
    advance();

`ifdef STB_MERGE_EN
    // Same-word stores collapse into one entry
    drive(1'b1, 32'h40, 32'hA, 1'b1, 32'h40);
    step();
    drive(1'b1, 32'h40, 32'hB, 1'b1, 32'h40);
    step();
    drive(1'b0, '0, '0, 1'b1, 32'h40);
    settle();
    check("merge_count", 32'(count), 32'd1);
    check("merge_data",  ld_data,    32'hB);
    advance();
    drive(1'b0, '0, '0, 1'b0, 32'h40);
    settle();
    check("merge_we",   32'(mem_we), 32'd1);
    check("merge_din",  mem_din,     32'hB);
    check("merge_addr", mem_addr,    32'h40);
    advance();
    settle();
    check("merge_empty", 32'(empty), 32'd1);
    advance();
`endif

    // Randomized traffic against the model
    for (int k = 0; k < 400; k++) begin
      reset = ($urandom_range(0, 59) != 0);
      hold  = ((k / 25) % 2 == 1) ? ($urandom_range(0, 9) != 0) : ($urandom_range(0, 3) == 0);
      r = $urandom;
      r[11:2] = 10'($urandom_range(0, 7));
      la = $urandom;
      la[11:2] = 10'($urandom_range(0, 7));
      drive(1'($urandom_range(0, 1)), r, $urandom, hold, la);
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
